// File: rtl/cr_lsu_pkg.sv
// Shared LSU bus definitions: size codes, AHB transfer codes, bus-stage FSM
// states and the registered address-phase / response payloads.
package cr_lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] haddr;
    logic            hwrite;
    logic [2:0]      hsize;
  } ahb_addr_t;

  typedef struct packed {
    logic            vld;
    logic            err;
    logic            misalign;
    logic [XLEN-1:0] rdata;
  } lsu_rsp_t;

  // Natural alignment check; the illegal size is rejected separately.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return |addr_lo;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cr_lsu_bus_data_align.sv
// Byte-lane handling for the LSU bus stage: store data replication across
// lanes and load data shift plus zero/sign extension.
module cr_lsu_bus_data_align
  import cr_lsu_pkg::*;
(
  input  size_e           st_size_i,
  input  logic [XLEN-1:0] st_wdata_i,
  input  size_e           ld_size_i,
  input  logic [1:0]      ld_offset_i,
  input  logic            ld_sign_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] st_wdata_c_o,
  output logic [XLEN-1:0] ld_rdata_c_o
);

  logic [XLEN-1:0] ld_shifted;

  always_comb begin
    case (st_size_i)
      SIZE_BYTE: st_wdata_c_o = {4{st_wdata_i[7:0]}};
      SIZE_HALF: st_wdata_c_o = {2{st_wdata_i[15:0]}};
      default:   st_wdata_c_o = st_wdata_i;
    endcase
  end

  assign ld_shifted = ld_rdata_i >> {ld_offset_i, 3'b000};

  always_comb begin
    case (ld_size_i)
      SIZE_BYTE: ld_rdata_c_o = {{24{ld_sign_i & ld_shifted[7]}}, ld_shifted[7:0]};
      SIZE_HALF: ld_rdata_c_o = {{16{ld_sign_i & ld_shifted[15]}}, ld_shifted[15:0]};
      default:   ld_rdata_c_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/cr_lsu_bus_ctrl.sv
// LSU bus-request stage: rejects misaligned/illegal requests locally and runs
// one non-pipelined AHB-Lite transfer per accepted request.
module cr_lsu_bus_ctrl
  import cr_lsu_pkg::*;
(
  input  logic            forever_cpuclk,
  input  logic            cpurst,
  input  logic            ctrl_bus_req_vld,
  output logic            ctrl_bus_req_rdy,
  input  logic            ctrl_bus_req_wr,
  input  logic [XLEN-1:0] ctrl_bus_req_addr,
  input  logic [1:0]      ctrl_bus_req_size,
  input  logic            ctrl_bus_req_sign,
  input  logic [XLEN-1:0] ctrl_bus_req_wdata,
  output logic [1:0]      lsu_hbus_htrans,
  output logic [XLEN-1:0] lsu_hbus_haddr,
  output logic            lsu_hbus_hwrite,
  output logic [2:0]      lsu_hbus_hsize,
  output logic [XLEN-1:0] lsu_hbus_hwdata,
  input  logic            hbus_lsu_hready,
  input  logic            hbus_lsu_hresp,
  input  logic [XLEN-1:0] hbus_lsu_hrdata,
  output logic            bus_ctrl_rsp_vld,
  output logic            bus_ctrl_rsp_err,
  output logic            bus_ctrl_rsp_misalign,
  output logic [XLEN-1:0] bus_ctrl_rsp_rdata
);

  state_e          state_q, state_d;
  ahb_addr_t       addr_q, addr_d;
  htrans_e         htrans_q, htrans_d;
  logic [XLEN-1:0] hwdata_q, hwdata_d;
  logic            sign_q, sign_d;
  logic            err_sticky_q, err_sticky_d;
  lsu_rsp_t        rsp_q, rsp_d;

  size_e           req_size_c;
  logic            accept_c;
  logic            illegal_c;
  logic            misalign_c;
  logic            rsp_err_c;
  logic [XLEN-1:0] st_wdata_c;
  logic [XLEN-1:0] ld_rdata_c;

  assign req_size_c = size_e'(ctrl_bus_req_size);
  assign accept_c   = ctrl_bus_req_vld & (state_q == ST_IDLE);
  assign illegal_c  = (req_size_c == SIZE_ILL);
  assign misalign_c = is_misaligned(req_size_c, ctrl_bus_req_addr[1:0]);
  assign rsp_err_c  = err_sticky_q | hbus_lsu_hresp;

  cr_lsu_bus_data_align u_align (
    .st_size_i    (req_size_c),
    .st_wdata_i   (ctrl_bus_req_wdata),
    .ld_size_i    (size_e'(addr_q.hsize[1:0])),
    .ld_offset_i  (addr_q.haddr[1:0]),
    .ld_sign_i    (sign_q),
    .ld_rdata_i   (hbus_lsu_hrdata),
    .st_wdata_c_o (st_wdata_c),
    .ld_rdata_c_o (ld_rdata_c)
  );

  // State register
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c && !illegal_c && !misalign_c) state_d = ST_ADDR;
      ST_ADDR: if (hbus_lsu_hready) state_d = ST_DATA;
      ST_DATA: if (hbus_lsu_hready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values; response fields are one-cycle pulses
  always_comb begin
    addr_d       = addr_q;
    htrans_d     = htrans_q;
    hwdata_d     = hwdata_q;
    sign_d       = sign_q;
    err_sticky_d = err_sticky_q;
    rsp_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (illegal_c) begin
            rsp_d.vld = 1'b1;
            rsp_d.err = 1'b1;
          end else if (misalign_c) begin
            rsp_d.vld      = 1'b1;
            rsp_d.misalign = 1'b1;
          end else begin
            addr_d.haddr  = ctrl_bus_req_addr;
            addr_d.hwrite = ctrl_bus_req_wr;
            addr_d.hsize  = {1'b0, ctrl_bus_req_size};
            htrans_d      = HTRANS_NONSEQ;
            hwdata_d      = st_wdata_c;
            sign_d        = ctrl_bus_req_sign;
            err_sticky_d  = 1'b0;
          end
        end
      end
      ST_ADDR: begin
        if (hbus_lsu_hready) htrans_d = HTRANS_IDLE;
      end
      ST_DATA: begin
        err_sticky_d = rsp_err_c;
        if (hbus_lsu_hready) begin
          rsp_d.vld   = 1'b1;
          rsp_d.err   = rsp_err_c;
          rsp_d.rdata = (rsp_err_c || addr_q.hwrite) ? '0 : ld_rdata_c;
        end
      end
      default: ;
    endcase
  end

  // Registered bus and response outputs
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      addr_q       <= '0;
      htrans_q     <= HTRANS_IDLE;
      hwdata_q     <= '0;
      sign_q       <= 1'b0;
      err_sticky_q <= 1'b0;
      rsp_q        <= '0;
    end else begin
      addr_q       <= addr_d;
      htrans_q     <= htrans_d;
      hwdata_q     <= hwdata_d;
      sign_q       <= sign_d;
      err_sticky_q <= err_sticky_d;
      rsp_q        <= rsp_d;
    end
  end

  assign ctrl_bus_req_rdy      = (state_q == ST_IDLE);
  assign lsu_hbus_htrans       = htrans_q;
  assign lsu_hbus_haddr        = addr_q.haddr;
  assign lsu_hbus_hwrite       = addr_q.hwrite;
  assign lsu_hbus_hsize        = addr_q.hsize;
  assign lsu_hbus_hwdata       = hwdata_q;
  assign bus_ctrl_rsp_vld      = rsp_q.vld;
  assign bus_ctrl_rsp_err      = rsp_q.err;
  assign bus_ctrl_rsp_misalign = rsp_q.misalign;
  assign bus_ctrl_rsp_rdata    = rsp_q.rdata;

endmodule

// File: tb/tb_cr_lsu_bus_ctrl.sv
// Directed plus randomized bench for cr_lsu_bus_ctrl with an arithmetic
// reference model of lane replication, load extraction and response timing.
module tb_cr_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_wdata;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic        rsp_vld;
  logic        rsp_err;
  logic        rsp_mis;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cr_lsu_bus_ctrl dut (
    .forever_cpuclk        (clk),
    .cpurst                (cpurst),
    .ctrl_bus_req_vld      (req_vld),
    .ctrl_bus_req_rdy      (req_rdy),
    .ctrl_bus_req_wr       (req_wr),
    .ctrl_bus_req_addr     (req_addr),
    .ctrl_bus_req_size     (req_size),
    .ctrl_bus_req_sign     (req_sign),
    .ctrl_bus_req_wdata    (req_wdata),
    .lsu_hbus_htrans       (htrans),
    .lsu_hbus_haddr        (haddr),
    .lsu_hbus_hwrite       (hwrite),
    .lsu_hbus_hsize        (hsize),
    .lsu_hbus_hwdata       (hwdata),
    .hbus_lsu_hready       (hready),
    .hbus_lsu_hresp        (hresp),
    .hbus_lsu_hrdata       (hrdata),
    .bus_ctrl_rsp_vld      (rsp_vld),
    .bus_ctrl_rsp_err      (rsp_err),
    .bus_ctrl_rsp_misalign (rsp_mis),
    .bus_ctrl_rsp_rdata    (rsp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rep(input int size, input logic [31:0] w);
    if (size == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] addr, input int size,
                                        input bit sign, input logic [31:0] d);
    longint nbits;
    longint v;
    if (size >= 2) return d;
    nbits = 64'(8 * (1 << size));
    v = longint'(d >> (8 * (addr % 4))) % (longint'(1) << nbits);
    if (sign && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
    return 32'(v);
  endfunction

  function automatic bit m_mis(input logic [31:0] addr, input int size);
    return (size < 3) && ((addr % (32'd1 << size)) != 0);
  endfunction

  // One request, issued in whatever cycle the task is entered (back-to-back
  // with a previous response); returns at the negedge of the response cycle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input int size, input bit sign,
                      input logic [31:0] wdata, input int aw, input int dw,
                      input logic [31:0] rdata, input logic [7:0] resp_mask, input bit resp_last);
    bit          exp_err;
    logic [31:0] exp_rd;
    req_vld   = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_size  = 2'(size);
    req_sign  = sign;
    req_wdata = wdata;
    #1;
    chk("req_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    if (size == 3 || m_mis(addr, size)) begin
      @(negedge clk);
      chk("rej_vld", 32'(rsp_vld), 32'd1);
      chk("rej_err", 32'(rsp_err), 32'(size == 3));
      chk("rej_mis", 32'(rsp_mis), 32'(size != 3));
      chk("rej_rdata", rsp_rdata, 32'd0);
      chk("rej_htrans", 32'(htrans), 32'd0);
      return;
    end
    for (int i = 0; i <= aw; i++) begin
      hready = (i == aw);
      @(negedge clk);
      chk("addr_htrans", 32'(htrans), 32'h2);
      chk("addr_haddr", haddr, addr);
      chk("addr_hsize", 32'(hsize), 32'(size));
      chk("addr_hwrite", 32'(hwrite), 32'(wr));
      chk("addr_rsp_vld", 32'(rsp_vld), 32'd0);
      if (wr) chk("addr_hwdata", hwdata, m_rep(size, wdata));
      @(posedge clk);
      #1;
    end
    exp_err = 1'b0;
    for (int i = 0; i <= dw; i++) begin
      hready = (i == dw);
      hresp  = (i == dw) ? resp_last : resp_mask[i % 8];
      hrdata = (i == dw) ? rdata : $urandom;
      exp_err |= hresp;
      @(negedge clk);
      chk("data_htrans", 32'(htrans), 32'd0);
      chk("data_rsp_vld", 32'(rsp_vld), 32'd0);
      if (wr) chk("data_hwdata", hwdata, m_rep(size, wdata));
      @(posedge clk);
      #1;
    end
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = $urandom;
    exp_rd = (wr || exp_err) ? 32'd0 : m_ext(addr, size, sign, rdata);
    @(negedge clk);
    chk("rsp_vld", 32'(rsp_vld), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_mis", 32'(rsp_mis), 32'd0);
    chk("rsp_rdata", rsp_rdata, exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sz;
    int          aw;
    int          dw;
    bit          wr;
    logic [31:0] a;
    logic [7:0]  mask;

    cpurst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_size = '0;
    req_sign = 1'b0; req_wdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_hsize", 32'(hsize), 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_mis", 32'(rsp_mis), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk);
    #1;
    cpurst = 1'b0;
    @(negedge clk);

    // Directed scenarios
    xfer(1'b0, 32'h100, 2, 1'b0, 32'h0, 0, 0, 32'hDEAD_BEEF, 8'h00, 1'b0);
    xfer(1'b0, 32'h103, 0, 1'b1, 32'h0, 0, 0, 32'h80AA_BBCC, 8'h00, 1'b0);
    xfer(1'b0, 32'h103, 0, 1'b0, 32'h0, 0, 0, 32'h80AA_BBCC, 8'h00, 1'b0);
    xfer(1'b1, 32'h202, 1, 1'b0, 32'h1234_ABCD, 0, 2, 32'h0, 8'h00, 1'b0);
    xfer(1'b0, 32'h101, 2, 1'b0, 32'h0, 0, 0, 32'h0, 8'h00, 1'b0);
    xfer(1'b0, 32'h100, 3, 1'b0, 32'h0, 0, 0, 32'h0, 8'h00, 1'b0);
    xfer(1'b0, 32'h300, 2, 1'b0, 32'h0, 0, 1, 32'h5555_5555, 8'h01, 1'b1);
    xfer(1'b0, 32'h302, 1, 1'b1, 32'h0, 1, 0, 32'h9876_0000, 8'h00, 1'b0);
    xfer(1'b0, 32'h304, 2, 1'b0, 32'h0, 0, 2, 32'h1111_2222, 8'h01, 1'b0);

    // Randomized traffic, always issued back-to-back with the previous response
    for (int n = 0; n < 60; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      a  = $urandom;
      if (sz < 3 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      wr = 1'($urandom_range(0, 1));
      aw = int'($urandom_range(0, 2));
      dw = int'($urandom_range(0, 2));
      mask = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      xfer(wr, a, sz, 1'($urandom_range(0, 1)), $urandom, aw, dw, $urandom, mask,
           $urandom_range(0, 7) == 0);
    end

    // Reset while the address phase is stalled
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 32'h400; req_size = 2'b10; req_sign = 1'b0;
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    hready  = 1'b0;
    @(negedge clk);
    chk("rst2_pre_htrans", 32'(htrans), 32'h2);
    @(posedge clk);
    #1;
    cpurst = 1'b1;
    @(posedge clk);
    #1;
    cpurst = 1'b0;
    hready = 1'b1;
    @(negedge clk);
    chk("rst2_htrans", 32'(htrans), 32'd0);
    chk("rst2_rdy", 32'(req_rdy), 32'd1);
    chk("rst2_haddr", haddr, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rst2_no_rsp", 32'(rsp_vld), 32'd0);
      @(negedge clk);
    end
    xfer(1'b0, 32'h400, 1, 1'b1, 32'h0, 0, 0, 32'h0000_8001, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
